// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, decoded control bundle, default widths.
package mips_pkg;

  localparam int unsigned DEF_DW = 32;
  localparam int unsigned DEF_AW = 5;
  localparam int unsigned OPW    = 6;
  localparam int unsigned FNW    = 6;

  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] OP_LW    = 6'h23;
  localparam logic [OPW-1:0] OP_SW    = 6'h2B;
  localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPW-1:0] OP_ORI   = 6'h0D;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RD   = 2'd1,
    DST_RT   = 2'd2
  } dst_sel_e;

  typedef struct packed {
    logic     regwrite;
    logic     memread;
    logic     memwrite;
    logic     alusrc;
    logic     branch;
    logic     zext;
    dst_sel_e dst_sel;
    logic     reads_rt;
  } ctrl_t;

endpackage

// File: rtl/id_decode.sv
// Combinational opcode -> control decoder; unknown opcodes decode as a NOP.
module id_decode
  import mips_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl_c
);

  always_comb begin
    ctrl_c         = '0;
    ctrl_c.dst_sel = DST_NONE;
    case (opcode)
      OP_RTYPE: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.dst_sel  = DST_RD;
        ctrl_c.reads_rt = 1'b1;
      end
      OP_LW: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memread  = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.dst_sel  = DST_RT;
      end
      OP_SW: begin
        ctrl_c.memwrite = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.reads_rt = 1'b1;
      end
      OP_BEQ: begin
        ctrl_c.branch   = 1'b1;
        ctrl_c.reads_rt = 1'b1;
      end
      OP_ADDI: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.dst_sel  = DST_RT;
      end
      OP_ORI: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.alusrc   = 1'b1;
        ctrl_c.dst_sel  = DST_RT;
        ctrl_c.zext     = 1'b1;
      end
      default: ctrl_c = '0;
    endcase
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID / operand-fetch stage: regfile addressing, writeback bypass, decode,
// load-use hazard detection and the ID/EX pipeline register.
module id_operand_stage
  import mips_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_valid,
  input  logic [31:0]   if_instr,
  input  logic [31:0]   if_pc4,
  output logic [AW-1:0] pr1,
  output logic [AW-1:0] pr2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  input  logic          wb_write,
  input  logic [AW-1:0] wb_wr,
  input  logic [DW-1:0] wb_wd,
  input  logic          ex_flush,
  output logic          stall,
  output logic          idex_valid,
  output logic [DW-1:0] idex_pc4,
  output logic [DW-1:0] idex_a,
  output logic [DW-1:0] idex_b,
  output logic [DW-1:0] idex_imm,
  output logic [AW-1:0] idex_rs,
  output logic [AW-1:0] idex_rt,
  output logic [AW-1:0] idex_dst,
  output logic [5:0]    idex_funct,
  output logic          idex_regwrite,
  output logic          idex_memread,
  output logic          idex_memwrite,
  output logic          idex_alusrc,
  output logic          idex_branch
);

  typedef struct packed {
    logic           valid;
    logic [DW-1:0]  pc4;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [DW-1:0]  imm;
    logic [AW-1:0]  rs;
    logic [AW-1:0]  rt;
    logic [AW-1:0]  dst;
    logic [FNW-1:0] funct;
    logic           regwrite;
    logic           memread;
    logic           memwrite;
    logic           alusrc;
    logic           branch;
  } idex_t;

  logic [OPW-1:0] opcode;
  logic [AW-1:0]  rs;
  logic [AW-1:0]  rt;
  logic [AW-1:0]  rd;
  ctrl_t          ctrl;
  logic [DW-1:0]  op_a;
  logic [DW-1:0]  op_b;
  logic [DW-1:0]  imm_ext;
  logic [AW-1:0]  dst;
  logic           hazard;
  idex_t          idex_d;
  idex_t          idex_q;

  assign opcode = if_instr[31:26];
  assign rs     = AW'(if_instr[25:21]);
  assign rt     = AW'(if_instr[20:16]);
  assign rd     = AW'(if_instr[15:11]);
  assign pr1    = rs;
  assign pr2    = rt;

  id_decode u_decode (
    .opcode (opcode),
    .ctrl_c (ctrl)
  );

  // $0 reads as zero; a same-cycle writeback wins over the stale regfile read.
  always_comb begin
    op_a = rd1;
    if (rs == '0) begin
      op_a = '0;
    end else if (wb_write && (wb_wr == rs)) begin
      op_a = wb_wd;
    end
  end

  always_comb begin
    op_b = rd2;
    if (rt == '0) begin
      op_b = '0;
    end else if (wb_write && (wb_wr == rt)) begin
      op_b = wb_wd;
    end
  end

  always_comb begin
    imm_ext = {{(DW-16){if_instr[15]}}, if_instr[15:0]};
    if (ctrl.zext) begin
      imm_ext = DW'(if_instr[15:0]);
    end
  end

  always_comb begin
    dst = '0;
    case (ctrl.dst_sel)
      DST_RD:  dst = rd;
      DST_RT:  dst = rt;
      default: dst = '0;
    endcase
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  assign hazard = idex_q.valid && idex_q.memread && (idex_q.dst != '0) && if_valid &&
                  ((idex_q.dst == rs) || ((idex_q.dst == rt) && ctrl.reads_rt));

  assign stall  = hazard && !ex_flush;

  always_comb begin
    idex_d = '0;
    if (!ex_flush && !hazard && if_valid) begin
      idex_d.valid    = 1'b1;
      idex_d.pc4      = DW'(if_pc4);
      idex_d.a        = op_a;
      idex_d.b        = op_b;
      idex_d.imm      = imm_ext;
      idex_d.rs       = rs;
      idex_d.rt       = rt;
      idex_d.dst      = dst;
      idex_d.funct    = (opcode == OP_RTYPE) ? if_instr[5:0] : '0;
      idex_d.regwrite = ctrl.regwrite;
      idex_d.memread  = ctrl.memread;
      idex_d.memwrite = ctrl.memwrite;
      idex_d.alusrc   = ctrl.alusrc;
      idex_d.branch   = ctrl.branch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign idex_valid    = idex_q.valid;
  assign idex_pc4      = idex_q.pc4;
  assign idex_a        = idex_q.a;
  assign idex_b        = idex_q.b;
  assign idex_imm      = idex_q.imm;
  assign idex_rs       = idex_q.rs;
  assign idex_rt       = idex_q.rt;
  assign idex_dst      = idex_q.dst;
  assign idex_funct    = idex_q.funct;
  assign idex_regwrite = idex_q.regwrite;
  assign idex_memread  = idex_q.memread;
  assign idex_memwrite = idex_q.memwrite;
  assign idex_alusrc   = idex_q.alusrc;
  assign idex_branch   = idex_q.branch;

endmodule
